// File: rtl/spirw_master_v_pkg.sv
// SPI RW master shared definitions.
// Command bytes are common with the slave-side code.
package spirw_master_v_pkg;

  localparam logic [7:0] SPIRW_CMD_WRITE = 8'h00;
  localparam logic [7:0] SPIRW_CMD_READ  = 8'h01;
  localparam logic [7:0] SPIRW_DUMMY     = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_DUMMY,
    ST_DATA,
    ST_HOLD,
    ST_GAP
  } state_t;

endpackage

// File: rtl/spirw_sclk_gen.sv
// SPI clock generator: D-cycle half periods, idle low.
// Hold freezes the phase counter while a write byte stalls.
module spirw_sclk_gen #(
  parameter int c_clk_div = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_en,
  input  logic i_hold,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [7:0] LAST = 8'(c_clk_div - 1);

  logic [7:0] r_cnt;
  logic       r_sclk;
  logic       w_tick;

  assign w_tick = i_en && !i_hold && (r_cnt == LAST);
  assign o_rise = w_tick && !r_sclk;
  assign o_fall = w_tick && r_sclk;
  assign o_sclk = r_sclk;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_hold) begin
      if (r_cnt == LAST) begin
        r_cnt  <= '0;
        r_sclk <= ~r_sclk;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/spirw_master_v.sv
// SPI RW master: mode 0, MSB first, cmd + address header,
// optional dummy byte on reads, then N data bytes.
module spirw_master_v
  import spirw_master_v_pkg::*;
#(
  parameter int c_addr_bits = 16,
  parameter int c_len_bits  = 16,
  parameter int c_clk_div   = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   req,
  output logic                   ready,
  input  logic                   rw,
  input  logic [c_addr_bits-1:0] addr,
  input  logic [c_len_bits-1:0]  len,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  output logic                   done,
  output logic                   csn,
  output logic                   sclk,
  output logic                   mosi,
  input  logic                   miso
);

  localparam int         HW   = 8 + c_addr_bits;
  localparam int         BW   = $clog2(HW);
  localparam logic [7:0] LAST = 8'(c_clk_div - 1);

  state_t                  r_state, w_next;
  logic [HW-1:0]           r_shift;
  logic [BW-1:0]           r_bit;
  logic [c_len_bits-1:0]   r_left;
  logic                    r_rw;
  logic [7:0]              r_rx;
  logic [7:0]              r_rx_data;
  logic                    r_rx_valid;
  logic                    r_done;
  logic                    r_csn;
  logic                    r_miso;
  logic [7:0]              r_wait;
  logic                    w_en, w_hold, w_xfer;
  logic                    w_rise, w_fall, w_last;
  logic                    w_sclk;

  assign w_en = (r_state == ST_HEADER) || (r_state == ST_DUMMY)
             || (r_state == ST_LOAD)   || (r_state == ST_DATA);
  assign w_hold = (r_state == ST_LOAD) && !r_rw && !tx_valid;
  assign w_xfer = (r_state == ST_LOAD) && (r_rw || tx_valid);
  assign w_last = (r_bit == '0);

  assign ready    = (r_state == ST_IDLE);
  assign tx_ready = (r_state == ST_LOAD) && !r_rw;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign done     = r_done;
  assign csn      = r_csn;
  assign sclk     = w_sclk;
  assign mosi     = r_shift[HW-1];

  spirw_sclk_gen #(
    .c_clk_div(c_clk_div)
  ) u_sclk (
    .clk   (clk),
    .rstn  (rstn),
    .i_en  (w_en),
    .i_hold(w_hold),
    .o_sclk(w_sclk),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (req) w_next = ST_HEADER;
      ST_HEADER: if (w_fall && w_last)
                   w_next = r_rw ? ST_DUMMY :
                            (r_left != '0) ? ST_LOAD : ST_HOLD;
      ST_DUMMY:  if (w_fall && w_last)
                   w_next = (r_left != '0) ? ST_LOAD : ST_HOLD;
      ST_LOAD:   if (w_xfer) w_next = ST_DATA;
      ST_DATA:   if (w_fall && w_last)
                   w_next = (r_left != '0) ? ST_LOAD : ST_HOLD;
      ST_HOLD:   if (r_wait == '0) w_next = ST_GAP;
      ST_GAP:    if (r_wait == '0) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift    <= '0;
      r_bit      <= '0;
      r_left     <= '0;
      r_rw       <= 1'b0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
      r_csn      <= 1'b1;
      r_miso     <= 1'b0;
      r_wait     <= '0;
    end else begin
      r_miso     <= miso;
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
      if (w_rise) r_rx <= {r_rx[6:0], r_miso};
      if (w_rise && (r_state == ST_DATA) && r_rw && w_last) begin
        r_rx_data  <= {r_rx[6:0], r_miso};
        r_rx_valid <= 1'b1;
      end
      unique case (r_state)
        ST_IDLE: if (req) begin
          r_shift <= {(rw ? SPIRW_CMD_READ : SPIRW_CMD_WRITE), addr};
          r_bit   <= BW'(HW - 1);
          r_left  <= len;
          r_rw    <= rw;
          r_csn   <= 1'b0;
        end
        ST_LOAD: if (w_xfer) begin
          r_shift <= r_rw ? '0 : {tx_data, {c_addr_bits{1'b0}}};
          r_bit   <= BW'(7);
          r_left  <= r_left - 1'b1;
        end
        ST_HOLD: if (r_wait == '0) begin
          r_csn  <= 1'b1;
          r_done <= 1'b1;
          r_wait <= LAST;
        end else begin
          r_wait <= r_wait - 8'd1;
        end
        ST_GAP: if (r_wait != '0) r_wait <= r_wait - 8'd1;
        default: if (w_fall) begin
          // segment boundary: mosi may only change here, on a falling edge
          if (w_last) begin
            r_shift <= (w_next == ST_DUMMY)
                     ? {SPIRW_DUMMY, {c_addr_bits{1'b0}}} : '0;
            r_bit   <= BW'(7);
            r_wait  <= LAST;
          end else begin
            r_shift <= r_shift << 1;
            r_bit   <= r_bit - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spirw_master_v.sv
// Bench for spirw_master_v: behavioural SPI slave with a
// 64KB memory, reference byte streams and timing formulas.
module tb_spirw_master_v;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic        req0 = 1'b0, rw0 = 1'b0;
  logic [15:0] addr0 = '0, len0 = '0;
  logic [7:0]  tx_data0 = '0;
  logic        tx_valid0 = 1'b0, miso0 = 1'b0;
  logic        ready0, tx_ready0, rx_valid0, done0;
  logic        csn0, sclk0, mosi0;
  logic [7:0]  rx_data0;

  logic        req1 = 1'b0, rw1 = 1'b0;
  logic [15:0] addr1 = '0, len1 = '0;
  logic [7:0]  tx_data1 = '0;
  logic        tx_valid1 = 1'b0, miso1 = 1'b0;
  logic        ready1, tx_ready1, rx_valid1, done1;
  logic        csn1, sclk1, mosi1;
  logic [7:0]  rx_data1;

  int total = 0;
  int bad = 0;

  bit [7:0] mem [65536];
  bit [7:0] ref_mem [65536];
  bit [7:0] mosi_log[$];
  bit [7:0] rx_q[$];
  bit [7:0] tx_q[$];
  bit [7:0] exp_q[$];

  typedef struct {
    int csn_low;
    int ndone;
    int nxfer;
    int nstall_bad;
    int nsclk;
    bit tmo;
  } res_t;

  always #5 clk = ~clk;

  spirw_master_v #(
    .c_addr_bits(16), .c_len_bits(16), .c_clk_div(2)
  ) u0 (
    .clk(clk), .rstn(rstn), .req(req0), .ready(ready0),
    .rw(rw0), .addr(addr0), .len(len0),
    .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .rx_data(rx_data0),
    .rx_valid(rx_valid0), .done(done0), .csn(csn0),
    .sclk(sclk0), .mosi(mosi0), .miso(miso0)
  );

  spirw_master_v #(
    .c_addr_bits(16), .c_len_bits(16), .c_clk_div(7)
  ) u1 (
    .clk(clk), .rstn(rstn), .req(req1), .ready(ready1),
    .rw(rw1), .addr(addr1), .len(len1),
    .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .rx_data(rx_data1),
    .rx_valid(rx_valid1), .done(done1), .csn(csn1),
    .sclk(sclk1), .mosi(mosi1), .miso(miso1)
  );

  // slave: sees sclk edges at the quiet clock phase
  logic [7:0]  s_sh = '0, s_out = '0;
  logic [15:0] s_addr = '0;
  int          s_bits = 0, s_idx = 0;
  bit          s_rw = 1'b0;
  logic        s_psclk = 1'b0;

  always @(negedge clk) begin
    if (csn0 !== 1'b0) begin
      s_bits = 0;
      s_idx  = 0;
      s_rw   = 1'b0;
      miso0  = 1'b0;
    end else if (sclk0 && !s_psclk) begin
      s_sh = {s_sh[6:0], mosi0};
      s_bits++;
      if (s_bits == 8) begin
        s_bits = 0;
        mosi_log.push_back(s_sh);
        case (s_idx)
          0: s_rw = s_sh[0];
          1: s_addr[15:8] = s_sh;
          2: s_addr[7:0] = s_sh;
          default: if (!s_rw) begin
            mem[s_addr] = s_sh;
            s_addr++;
          end
        endcase
        if (s_rw && s_idx >= 3) begin
          s_out = mem[s_addr];
          s_addr++;
        end
        s_idx++;
      end
    end else if (!sclk0 && s_psclk) begin
      miso0 = s_out[7];
      s_out = s_out << 1;
    end
    s_psclk = sclk0;
  end

  function automatic int exp_low(int d, int r, int n, int st);
    return 2 * d * (24 + 8 * (n + r)) + d + st;
  endfunction

  function automatic void build_exp(bit r, logic [15:0] a, int n);
    exp_q.delete();
    exp_q.push_back(r ? 8'h01 : 8'h00);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    if (r) begin
      for (int i = 0; i <= n; i++) exp_q.push_back(8'h00);
    end else begin
      for (int i = 0; i < n; i++) exp_q.push_back(tx_q[i]);
    end
  endfunction

  function automatic bit q_eq(bit [7:0] x[$], bit [7:0] y[$]);
    if (x.size() != y.size()) return 1'b0;
    for (int i = 0; i < x.size(); i++)
      if (x[i] != y[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_txn(input bit r, input logic [15:0] a,
                        input int n, input int stall_idx,
                        input int stall_cyc, output res_t res);
    int k, st, cyc;
    bit seen_done;
    logic p_sclk;
    res = '{0, 0, 0, 0, 0, 1'b0};
    rx_q.delete();
    mosi_log.delete();
    @(posedge clk); #1;
    cyc = 0;
    while (ready0 !== 1'b1 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    req0 = 1'b1; rw0 = r; addr0 = a; len0 = 16'(n);
    @(posedge clk); #1;
    req0 = 1'b0;
    rw0 = 1'($urandom);
    addr0 = 16'($urandom);
    len0 = 16'($urandom);
    k = 0; st = 0; cyc = 0; p_sclk = 1'b0; seen_done = 1'b0;
    while (!(seen_done && ready0) && cyc < 20000) begin
      if (csn0 === 1'b0) res.csn_low++;
      if (done0) begin res.ndone++; seen_done = 1'b1; end
      if (sclk0 && !p_sclk) res.nsclk++;
      p_sclk = sclk0;
      if (rx_valid0) rx_q.push_back(rx_data0);
      if (tx_ready0 && k == stall_idx && st < stall_cyc) begin
        tx_valid0 = 1'b0;
        st++;
        if (sclk0 !== 1'b0 || csn0 !== 1'b0) res.nstall_bad++;
      end else begin
        tx_valid0 = 1'b1;
        tx_data0 = (k < tx_q.size()) ? tx_q[k] : 8'($urandom);
      end
      if (tx_valid0 && tx_ready0) begin
        res.nxfer++;
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    tx_valid0 = 1'b0;
    res.tmo = (cyc >= 20000);
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++; if (csn0 !== 1'b1) begin bad++;
      $display("FAIL rst_csn got %b want 1", csn0); end
    total++; if (sclk0 !== 1'b0) begin bad++;
      $display("FAIL rst_sclk got %b want 0", sclk0); end
    total++; if (mosi0 !== 1'b0) begin bad++;
      $display("FAIL rst_mosi got %b want 0", mosi0); end
    total++; if (ready0 !== 1'b1) begin bad++;
      $display("FAIL rst_ready got %b want 1", ready0); end
    total++; if (tx_ready0 !== 1'b0) begin bad++;
      $display("FAIL rst_tx_ready got %b want 0", tx_ready0); end
    total++; if (rx_valid0 !== 1'b0 || done0 !== 1'b0) begin bad++;
      $display("FAIL rst_pulses got %b%b want 00", rx_valid0, done0); end
    total++; if (rx_data0 !== 8'h00) begin bad++;
      $display("FAIL rst_rx_data got %h want 00", rx_data0); end
  endtask

  task automatic test_write_single();
    res_t res;
    tx_q = '{8'hA5};
    do_txn(1'b0, 16'h1234, 1, -1, 0, res);
    ref_mem[16'h1234] = 8'hA5;
    build_exp(1'b0, 16'h1234, 1);
    total++; if (res.tmo) begin bad++;
      $display("FAIL w1_timeout got 1 want 0"); end
    total++; if (!q_eq(mosi_log, exp_q)) begin bad++;
      $display("FAIL w1_mosi got %p want %p", mosi_log, exp_q); end
    total++; if (mem[16'h1234] !== 8'hA5) begin bad++;
      $display("FAIL w1_mem got %h want a5", mem[16'h1234]); end
    total++; if (res.csn_low != 130) begin bad++;
      $display("FAIL w1_csn_low got %0d want 130", res.csn_low); end
    total++; if (res.ndone != 1 || res.nxfer != 1) begin bad++;
      $display("FAIL w1_done_xfer got %0d/%0d want 1/1",
               res.ndone, res.nxfer); end
  endtask

  task automatic test_write_burst();
    res_t res;
    bit ok;
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_txn(1'b0, 16'h1234, 4, -1, 0, res);
    for (int i = 0; i < 4; i++) ref_mem[16'h1234 + i] = tx_q[i];
    build_exp(1'b0, 16'h1234, 4);
    ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (mem[16'h1234 + i] != ref_mem[16'h1234 + i]) ok = 1'b0;
    total++; if (!ok) begin bad++;
      $display("FAIL w4_mem got %h%h%h%h want 01020304",
               mem[16'h1234], mem[16'h1235],
               mem[16'h1236], mem[16'h1237]); end
    total++; if (res.nxfer != 4) begin bad++;
      $display("FAIL w4_xfers got %0d want 4", res.nxfer); end
    total++; if (!q_eq(mosi_log, exp_q)) begin bad++;
      $display("FAIL w4_mosi got %p want %p", mosi_log, exp_q); end
    total++; if (res.csn_low != exp_low(2, 0, 4, 0)) begin bad++;
      $display("FAIL w4_csn_low got %0d want %0d",
               res.csn_low, exp_low(2, 0, 4, 0)); end
  endtask

  task automatic test_read_burst();
    res_t res;
    bit [7:0] want[$];
    tx_q.delete();
    do_txn(1'b1, 16'h1234, 4, -1, 0, res);
    for (int i = 0; i < 4; i++) want.push_back(ref_mem[16'h1234 + i]);
    build_exp(1'b1, 16'h1234, 4);
    total++; if (!q_eq(rx_q, want)) begin bad++;
      $display("FAIL r4_data got %p want %p", rx_q, want); end
    total++; if (!q_eq(mosi_log, exp_q)) begin bad++;
      $display("FAIL r4_mosi got %p want %p", mosi_log, exp_q); end
    total++; if (res.csn_low != exp_low(2, 1, 4, 0)
                 || res.ndone != 1 || res.nxfer != 0) begin bad++;
      $display("FAIL r4_timing got low=%0d done=%0d xfer=%0d want %0d/1/0",
               res.csn_low, res.ndone, res.nxfer,
               exp_low(2, 1, 4, 0)); end
  endtask

  task automatic test_stall();
    res_t res;
    tx_q = '{8'($urandom), 8'($urandom)};
    do_txn(1'b0, 16'h2000, 2, 1, 20, res);
    ref_mem[16'h2000] = tx_q[0];
    ref_mem[16'h2001] = tx_q[1];
    total++; if (mem[16'h2000] != ref_mem[16'h2000]
                 || mem[16'h2001] != ref_mem[16'h2001]) begin bad++;
      $display("FAIL stall_mem got %h%h want %h%h",
               mem[16'h2000], mem[16'h2001], tx_q[0], tx_q[1]); end
    total++; if (res.nstall_bad != 0) begin bad++;
      $display("FAIL stall_pins got %0d bad cycles want 0",
               res.nstall_bad); end
    total++; if (res.csn_low != exp_low(2, 0, 2, 20)) begin bad++;
      $display("FAIL stall_csn_low got %0d want %0d",
               res.csn_low, exp_low(2, 0, 2, 20)); end
  endtask

  task automatic test_random();
    res_t res;
    logic [15:0] a;
    int n, si, sc;
    bit [7:0] want[$];
    for (int it = 0; it < 6; it++) begin
      a = 16'($urandom);
      n = $urandom_range(1, 5);
      si = $urandom_range(0, n - 1);
      sc = $urandom_range(0, 5);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      do_txn(1'b0, a, n, si, sc, res);
      for (int i = 0; i < n; i++) ref_mem[16'(a + i)] = tx_q[i];
      build_exp(1'b0, a, n);
      total++; if (!q_eq(mosi_log, exp_q)
                   || res.csn_low != exp_low(2, 0, n, sc)) begin bad++;
        $display("FAIL rnd_wr a=%h n=%0d low=%0d want %0d",
                 a, n, res.csn_low, exp_low(2, 0, n, sc)); end
      tx_q.delete();
      do_txn(1'b1, a, n, -1, 0, res);
      want.delete();
      for (int i = 0; i < n; i++) want.push_back(ref_mem[16'(a + i)]);
      total++; if (!q_eq(rx_q, want)) begin bad++;
        $display("FAIL rnd_rd a=%h got %p want %p", a, rx_q, want); end
    end
  endtask

  task automatic test_read_zero();
    res_t res;
    tx_q.delete();
    do_txn(1'b1, 16'hBEEF, 0, -1, 0, res);
    build_exp(1'b1, 16'hBEEF, 0);
    total++; if (rx_q.size() != 0 || res.nxfer != 0) begin bad++;
      $display("FAIL r0_handshake got rx=%0d xfer=%0d want 0/0",
               rx_q.size(), res.nxfer); end
    total++; if (res.nsclk != 32) begin bad++;
      $display("FAIL r0_sclk got %0d want 32", res.nsclk); end
    total++; if (res.csn_low != exp_low(2, 1, 0, 0)
                 || !q_eq(mosi_log, exp_q)) begin bad++;
      $display("FAIL r0_frame got low=%0d %p want %0d %p",
               res.csn_low, mosi_log, exp_low(2, 1, 0, 0), exp_q); end
  endtask

  task automatic test_timing_d7();
    int setup = 0, hold = 0, gap = 0, pulses = 0;
    int low = 0, cyc = 0, nrx = 0;
    bit started = 1'b0, sawdone = 1'b0;
    logic p = 1'b0;
    @(posedge clk); #1;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 16'($urandom); len1 = '0;
    @(posedge clk); #1;
    req1 = 1'b0;
    while (!(sawdone && ready1) && cyc < 5000) begin
      if (csn1 === 1'b0) begin
        low++;
        if (sclk1) begin started = 1'b1; hold = 0; end
        else if (!started) setup++;
        else hold++;
      end else if (!ready1) begin
        gap++;
      end
      if (sclk1 && !p) pulses++;
      p = sclk1;
      if (done1) sawdone = 1'b1;
      if (rx_valid1) nrx++;
      @(posedge clk); #1;
      cyc++;
    end
    total++; if (cyc >= 5000) begin bad++;
      $display("FAIL d7_timeout got %0d cycles want <5000", cyc); end
    total++; if (setup != 7 || hold != 7 || gap != 7) begin bad++;
      $display("FAIL d7_setup_hold_gap got %0d/%0d/%0d want 7/7/7",
               setup, hold, gap); end
    total++; if (pulses != 32 || low != exp_low(7, 1, 0, 0)
                 || nrx != 0) begin bad++;
      $display("FAIL d7_frame got p=%0d low=%0d rx=%0d want 32/%0d/0",
               pulses, low, nrx, exp_low(7, 1, 0, 0)); end
  endtask

  task automatic test_reset_mid();
    res_t res;
    int cyc = 0, nd = 0;
    @(posedge clk); #1;
    while (ready0 !== 1'b1 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    req0 = 1'b1; rw0 = 1'b0; addr0 = 16'h4321; len0 = 16'd1;
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (csn0 !== 1'b0) begin bad++;
      $display("FAIL mid_busy csn got %b want 0", csn0); end
    #2;
    rstn = 1'b0;
    #1;
    total++; if (csn0 !== 1'b1 || sclk0 !== 1'b0) begin bad++;
      $display("FAIL mid_async got csn=%b sclk=%b want 1/0",
               csn0, sclk0); end
    repeat (3) begin
      @(posedge clk); #1;
      if (done0) nd++;
    end
    rstn = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done0) nd++;
    end
    total++; if (nd != 0) begin bad++;
      $display("FAIL mid_done got %0d pulses want 0", nd); end
    tx_q = '{8'h5A};
    do_txn(1'b0, 16'h4321, 1, -1, 0, res);
    ref_mem[16'h4321] = 8'h5A;
    total++; if (mem[16'h4321] != ref_mem[16'h4321]
                 || res.ndone != 1 || res.csn_low != 130) begin bad++;
      $display("FAIL mid_after got %h done=%0d low=%0d want 5a/1/130",
               mem[16'h4321], res.ndone, res.csn_low); end
  endtask

  initial begin
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    @(negedge clk);
    rstn = 1'b1;
    test_reset();
    test_write_single();
    test_write_burst();
    test_read_burst();
    test_stall();
    test_random();
    test_read_zero();
    test_timing_d7();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
